// File: rtl/bin2sseg_fmt.sv
// -----------------------------------------------------------------------------
// bin2sseg_fmt
//
// Purpose:
//   Front end of the four-digit multiplexed 7-segment display driver.
//   - Accepts an unsigned binary value through a start/ready handshake.
//   - Converts it to four BCD digits with a sequential double-dabble engine,
//     one shift per clock.
//   - Encodes each digit into an active-low 8-bit segment pattern.
//   - Holds the four registered patterns on seg3..seg0 until the next
//     conversion completes.
//
// Pattern format (active-low, 0 = lit):
//   bit7     = decimal point
//   bits6:0  = {a,b,c,d,e,f,g}
//
// Parameters:
//   WIDTH   width of the binary input, legal range 4..14.
//           The displayable range is 0..9999.
//
// Ports:
//   clk     in   1      system clock, rising-edge active
//   reset   in   1      asynchronous reset, active low
//   start   in   1      conversion request, sampled only while ready=1
//   bin     in   WIDTH  value to display, latched on an accepted start
//   dp_in   in   4      decimal-point request per digit (bit i -> digit i),
//                       latched on an accepted start
//   ready   out  1      idle and able to accept start
//   done    out  1      one-cycle pulse when new patterns appear
//   ovf     out  1      last accepted value exceeded 9999
//   seg3    out  8      pattern for digit 3 (most significant)
//   seg2    out  8      pattern for digit 2
//   seg1    out  8      pattern for digit 1
//   seg0    out  8      pattern for digit 0 (least significant)
//
// Build option:
//   LZ_BLANK_EN  when defined, leading zeros on digits 3..1 are blanked.
//                seg0 always shows its digit, and no blanking is applied
//                on overflow. When undefined, all four digits always show.
// -----------------------------------------------------------------------------
module bin2sseg_fmt #(
    parameter int unsigned WIDTH = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    input  logic [3:0]       dp_in,
    output logic             ready,
    output logic             done,
    output logic             ovf,
    output logic [7:0]       seg3,
    output logic [7:0]       seg2,
    output logic [7:0]       seg1,
    output logic [7:0]       seg0
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ENC   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [15:0]       bcd_q,   bcd_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [3:0]        dp_q,    dp_d;
    logic              ovfp_q,  ovfp_d;
    logic              ovf_q,   ovf_d;
    logic              done_q,  done_d;
    logic [3:0][7:0]   seg_q,   seg_d;

    logic [15:0]       bcd_adj;
    logic [3:0][7:0]   pat;

    // Active-low a..g code for one decimal digit.
    function automatic logic [6:0] digit_code(input logic [3:0] d);
        logic [6:0] c;
        case (d)
            4'd0:    c = 7'b0000001;
            4'd1:    c = 7'b1001111;
            4'd2:    c = 7'b0010010;
            4'd3:    c = 7'b0000110;
            4'd4:    c = 7'b1001100;
            4'd5:    c = 7'b0100100;
            4'd6:    c = 7'b0100000;
            4'd7:    c = 7'b0001111;
            4'd8:    c = 7'b0000000;
            4'd9:    c = 7'b0000100;
            default: c = 7'b1111111;
        endcase
        return c;
    endfunction

    // Double-dabble correction: add 3 to every nibble >= 5 before shifting.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Pattern formation from the finished BCD value.
    always_comb begin
        logic [3:0] blank;
        blank = '0;
`ifdef LZ_BLANK_EN
        // A digit blanks only if it and every digit to its left are zero.
        blank[3] = (bcd_q[15:12] == 4'd0);
        blank[2] = blank[3] && (bcd_q[11:8] == 4'd0);
        blank[1] = blank[2] && (bcd_q[7:4]  == 4'd0);
`endif
        for (int unsigned i = 0; i < 4; i++) begin
            if (ovfp_q) begin
                pat[i] = {~dp_q[i], 7'b1111110};
            end else if (blank[i]) begin
                pat[i] = {~dp_q[i], 7'b1111111};
            end else begin
                pat[i] = {~dp_q[i], digit_code(bcd_q[4*i +: 4])};
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        dp_d    = dp_q;
        ovfp_d  = ovfp_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        seg_d   = seg_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = bin;
                    dp_d    = dp_in;
                    ovfp_d  = (16'(bin) > 16'd9999);
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d   = {bcd_adj[14:0], shift_q[WIDTH-1]};
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ENC;
                end
            end
            ENC: begin
                seg_d   = pat;
                ovf_d   = ovfp_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            dp_q    <= '0;
            ovfp_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            seg_q   <= '1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            dp_q    <= dp_d;
            ovfp_q  <= ovfp_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            seg_q   <= seg_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign ovf   = ovf_q;
    assign seg3  = seg_q[3];
    assign seg2  = seg_q[2];
    assign seg1  = seg_q[1];
    assign seg0  = seg_q[0];

endmodule

// File: tb/tb_bin2sseg_fmt.sv
// -----------------------------------------------------------------------------
// tb_bin2sseg_fmt
//
// Purpose:
//   Directed self-checking bench for bin2sseg_fmt (WIDTH=14). Expected
//   segment patterns are hand-computed constants. Inputs change on the
//   falling edge; outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_bin2sseg_fmt;

    localparam int unsigned W = 14;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] bin = '0;
    logic [3:0]   dp_in = '0;
    logic         ready, done, ovf;
    logic [7:0]   seg3, seg2, seg1, seg0;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    bin2sseg_fmt #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .dp_in (dp_in),
        .ready (ready),
        .done  (done),
        .ovf   (ovf),
        .seg3  (seg3),
        .seg2  (seg2),
        .seg1  (seg1),
        .seg0  (seg0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_segs(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                              input logic [7:0] e1, input logic [7:0] e0, input logic eovf);
        check({tag, "_seg3"}, 32'(seg3), 32'(e3));
        check({tag, "_seg2"}, 32'(seg2), 32'(e2));
        check({tag, "_seg1"}, 32'(seg1), 32'(e1));
        check({tag, "_seg0"}, 32'(seg0), 32'(e0));
        check({tag, "_ovf"},  32'(ovf),  32'(eovf));
    endtask

    // Called just after the accepting edge; returns edges until done is seen.
    task automatic wait_done(output int unsigned lat, output bit ready_low);
        lat = 0;
        ready_low = 1'b1;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (ready) ready_low = 1'b0;
        end
    endtask

    task automatic run(input string tag, input logic [W-1:0] v, input logic [3:0] dp,
                       input logic [7:0] e3, input logic [7:0] e2,
                       input logic [7:0] e1, input logic [7:0] e0, input logic eovf);
        int unsigned lat;
        bit          rl;
        @(negedge clk);
        bin   = v;
        dp_in = dp;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_ready_after_E0"}, 32'(ready), 32'd0);
        wait_done(lat, rl);
        check({tag, "_latency"}, lat, 32'd15);
        check({tag, "_ready_low"}, 32'(rl), 32'd1);
        check({tag, "_ready_at_done"}, 32'(ready), 32'd1);
        check_segs(tag, e3, e2, e1, e0, eovf);
        @(posedge clk);
        #1;
        check({tag, "_done_clears"}, 32'(done), 32'd0);
    endtask

    initial begin
        int unsigned lat;
        bit          rl;
        bit          saw_done;

        // Reset values
        #12;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done",  32'(done),  32'd0);
        check_segs("rst", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        run("v1234", 14'd1234, 4'b0000, 8'hCF, 8'h92, 8'h86, 8'hCC, 1'b0);
        run("v9999", 14'd9999, 4'b0000, 8'h84, 8'h84, 8'h84, 8'h84, 1'b0);
        run("v10000", 14'd10000, 4'b0000, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 1'b1);
        check("ovf_held", 32'(ovf), 32'd1);
`ifdef LZ_BLANK_EN
        run("v0", 14'd0, 4'b0000, 8'hFF, 8'hFF, 8'hFF, 8'h81, 1'b0);
        run("v7", 14'd7, 4'b0000, 8'hFF, 8'hFF, 8'hFF, 8'h8F, 1'b0);
`else
        run("v0", 14'd0, 4'b0000, 8'h81, 8'h81, 8'h81, 8'h81, 1'b0);
        run("v7", 14'd7, 4'b0000, 8'h81, 8'h81, 8'h81, 8'h8F, 1'b0);
`endif
        run("v1234dp", 14'd1234, 4'b0100, 8'hCF, 8'h12, 8'h86, 8'hCC, 1'b0);
        run("ovfdp", 14'd16383, 4'b1001, 8'h7E, 8'hFE, 8'hFE, 8'h7E, 1'b1);

        // Start while busy is ignored; start held across done is accepted.
        @(negedge clk);
        bin = 14'd1234; dp_in = 4'b0000; start = 1'b1;
        @(posedge clk); #1;                 // E0
        start = 1'b0;
        repeat (2) @(posedge clk);          // E1, E2
        @(negedge clk);
        bin = 14'd5; dp_in = 4'b1111; start = 1'b1;
        @(posedge clk); #1;                 // E3: ignored
        start = 1'b0;
        repeat (11) @(posedge clk);         // E4..E14
        @(negedge clk);
        bin = 14'd42; dp_in = 4'b0000; start = 1'b1;
        @(posedge clk); #1;                 // E15: done cycle
        check("busy_done", 32'(done), 32'd1);
        check_segs("busy", 8'hCF, 8'h92, 8'h86, 8'hCC, 1'b0);
        @(posedge clk); #1;                 // start still high -> accepted
        start = 1'b0;
        check("held_accept_ready", 32'(ready), 32'd0);
        check_segs("held_hold", 8'hCF, 8'h92, 8'h86, 8'hCC, 1'b0);
        wait_done(lat, rl);
        check("held_latency", lat, 32'd15);
`ifdef LZ_BLANK_EN
        check_segs("held42", 8'hFF, 8'hFF, 8'hCC, 8'h92, 1'b0);
`else
        check_segs("held42", 8'h81, 8'h81, 8'hCC, 8'h92, 1'b0);
`endif

        // Reset mid-conversion aborts without any output update.
        @(negedge clk);
        bin = 14'd9999; start = 1'b1;
        @(posedge clk); #1;                 // E0
        start = 1'b0;
        repeat (5) @(posedge clk);          // E5
        #1;
        reset = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done",  32'(done),  32'd0);
        check_segs("abort", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        check_segs("abort_hold", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
`ifdef LZ_BLANK_EN
        run("v42", 14'd42, 4'b0000, 8'hFF, 8'hFF, 8'hCC, 8'h92, 1'b0);
`else
        run("v42", 14'd42, 4'b0000, 8'h81, 8'h81, 8'hCC, 8'h92, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2sseg_fmt.md
Name: bin2sseg_fmt

Overview:
- Upstream stage of the four-digit multiplexed 7-segment display driver.
- Accepts a binary value through a start/ready handshake and converts it to four BCD digits with a sequential double-dabble engine (one shift per clock).
- Encodes each digit into an 8-bit active-low segment pattern and holds the four registered patterns on seg3..seg0, which wire directly to the mux's four pattern inputs.

Parameters:
- WIDTH, 14, width of the binary input. Legal range 4..14. Displayable range is 0..9999.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  conversion request; sampled only while ready=1.
- bin  input  WIDTH  unsigned value to display; latched on accepted start.
- dp_in  input  4  decimal-point request per digit, active-high, bit i drives digit i; latched on accepted start.
- ready  output  1  high when idle and able to accept start.
- done  output  1  one-cycle pulse when new patterns appear on seg3..seg0.
- ovf  output  1  high when the last accepted value exceeded 9999.
- seg3  output  8  pattern for digit 3 (most significant).
- seg2  output  8  pattern for digit 2.
- seg1  output  8  pattern for digit 1.
- seg0  output  8  pattern for digit 0 (least significant).

Behaviour:
- Pattern format, active-low:
  - bit7 = dp (0 = lit).
  - bits6:0 = {a,b,c,d,e,f,g} (0 = lit).
- Digit codes for bits6:0:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111, dash=1111110
- Reset (reset=0, asynchronous):
  - state=IDLE; ready=1, done=0, ovf=0.
  - seg3..seg0=8'hFF (all dark).
  - Internal shift/BCD registers cleared.
  - Reset asserted mid-conversion aborts the conversion with no partial update of the seg outputs.
- FSM states: IDLE, SHIFT, ENC.
  - IDLE: ready=1. If start=1 at edge E0, latch bin, dp_in and ovf_pending=(bin>9999); clear BCD; bit counter=0; go to SHIFT; ready drops after E0.
  - SHIFT: on each edge E1..E_WIDTH:
    - Add 3 to every BCD nibble >=5.
    - Then shift {bcd, bin_shift} left by one.
    - After edge E_WIDTH, go to ENC.
  - ENC: edge E_WIDTH+1 registers seg3..seg0, sets ovf=ovf_pending, sets done=1 and ready=1, and returns to IDLE.
  - done clears on the following edge.
- Latency: outputs change WIDTH+1 edges after the accepting edge (15 for WIDTH=14).
- Handshake rules:
  - start while ready=0 is ignored; it is neither queued nor does it alter the latched data.
  - start=1 in the done cycle (ready=1) is accepted normally.
- Outputs are held between conversions; bin and dp_in may change freely after acceptance.
- Overflow: all four digits = dash with dp applied, i.e. 8'hFE per digit when dp off; ovf=1 until the next conversion completes.
- Width rule: BCD register is 16 bits. No nibble can exceed 9 after correction because WIDTH<=14.

Optional Feature:
- Macro LZ_BLANK_EN.
- Defined: leading-zero blanking. Digits 3..1 that are zero and have only zeros to their left show blank (bits6:0=1111111); dp bit still honoured. seg0 is never blanked, so value 0 shows a single "0". Not applied on overflow.
- Undefined: all four digits always shown, including leading zeros.

Test Plan:
- Reset, then bin=1234, dp_in=0, start pulse -> after 15 edges seg3..seg0=CF,92,86,CC; done=1 for exactly one cycle; ovf=0; ready=0 during edges E0..E14.
- bin=9999 -> seg3..seg0=84,84,84,84, ovf=0. Then bin=10000 -> FE,FE,FE,FE, ovf=1. Then bin=0 -> ovf returns to 0.
- bin=7:
  - Without LZ_BLANK_EN -> 81,81,81,8F.
  - With LZ_BLANK_EN -> FF,FF,FF,8F.
  - bin=0 with LZ_BLANK_EN -> FF,FF,FF,81.
- bin=1234, dp_in=4'b0100 -> seg2=8'h12, others CF,86,CC unchanged format.
- Start pulsed with bin=5 at E3 of a 1234 conversion -> ignored; result is 1234. Start held high across the done cycle -> second conversion accepted on that edge.
- reset=0 asserted at E5 of a conversion -> segs immediately FF, done=0, ready=1, no done pulse. Release, then start with bin=42 -> 81,81,CC,92.
